// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller.
// States, IO region tag and access width codes.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        COOL
    } state_t;

    localparam logic [1:0] IO_TAG = 2'b11;

    localparam logic [5:0] LEN_B = 6'd8;
    localparam logic [5:0] LEN_H = 6'd16;
    localparam logic [5:0] LEN_W = 6'd32;

    function automatic logic [2:0] byte_cnt(input logic [5:0] len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            LEN_W:   return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response and RAM bus bundle for mem_ctrl.
// slave is the controller side, master the LSB/IF/RAM side.
interface mem_ctrl_if;

    logic        lsb_nd;
    logic        lsb_out;
    logic [5:0]  lsb_len;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_data;
    logic        lsb_flg;
    logic [31:0] lsb_res;
    logic        lsb_commit;

    logic        if_nd;
    logic [31:0] if_addr;
    logic        if_flg;
    logic [31:0] if_inst;

    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    modport slave (
        input  lsb_nd, lsb_out, lsb_len, lsb_addr, lsb_data,
        input  if_nd, if_addr,
        input  mem_din, io_buffer_full,
        output lsb_flg, lsb_res, lsb_commit,
        output if_flg, if_inst,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output lsb_nd, lsb_out, lsb_len, lsb_addr, lsb_data,
        output if_nd, if_addr,
        output mem_din, io_buffer_full,
        input  lsb_flg, lsb_res, lsb_commit,
        input  if_flg, if_inst,
        input  mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating store, load and fetch
// requests onto an 8-bit RAM port with 1-cycle read latency.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    input  logic       reset,
    mem_ctrl_if.slave  bus
);

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  k_q;
    logic [2:0]  n_q;
    logic        io_q;
    logic        is_if_q;
    logic [31:0] mem_a_q;
    logic [7:0]  mem_dout_q;
    logic [31:0] wdata_q;
    logic [31:0] sh_q;
    logic        lsb_flg_q;
    logic        lsb_commit_q;
    logic        if_flg_q;
    logic [31:0] lsb_res_q;
    logic [31:0] if_inst_q;

    logic        st_take;
    logic        ld_take;
    logic        if_take;
    logic        wr_stall;
    logic [31:0] sh_nxt;
    logic [1:0]  gap;
    logic [31:0] rd_word;

    // Byte k-1 arrives while byte k is addressed; realign after the last one.
    assign sh_nxt  = {bus.mem_din, sh_q[31:8]};
    assign gap     = 2'(3'd4 - n_q);
    assign rd_word = sh_nxt >> {gap, 3'b000};

    always_comb begin
        state_d  = state_q;
        st_take  = bus.lsb_out;
        ld_take  = !bus.lsb_out && bus.lsb_nd;
        if_take  = !bus.lsb_out && !bus.lsb_nd && bus.if_nd;
        wr_stall = io_q && bus.io_buffer_full;
        unique case (state_q)
            IDLE: begin
                if (!reset) begin
                    if (st_take)
                        state_d = WRITE;
                    else if (ld_take || if_take)
                        state_d = READ;
                end
            end
            READ: begin
                if (reset)
                    state_d = IDLE;
                else if (k_q == n_q)
                    state_d = COOL;
            end
            WRITE: begin
                if (!wr_stall && k_q == n_q - 3'd1)
                    state_d = COOL;
            end
            COOL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else if (rdy)
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q          <= 3'd0;
            n_q          <= 3'd0;
            io_q         <= 1'b0;
            is_if_q      <= 1'b0;
            mem_a_q      <= 32'd0;
            mem_dout_q   <= 8'd0;
            wdata_q      <= 32'd0;
            sh_q         <= 32'd0;
            lsb_flg_q    <= 1'b0;
            lsb_commit_q <= 1'b0;
            if_flg_q     <= 1'b0;
            lsb_res_q    <= 32'd0;
            if_inst_q    <= 32'd0;
        end else if (rdy) begin
            lsb_flg_q    <= 1'b0;
            lsb_commit_q <= 1'b0;
            if_flg_q     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    k_q        <= 3'd0;
                    sh_q       <= 32'd0;
                    mem_dout_q <= 8'd0;
                    if (state_d == WRITE) begin
                        n_q        <= byte_cnt(bus.lsb_len);
                        io_q       <= bus.lsb_addr[17:16] == IO_TAG;
                        mem_a_q    <= bus.lsb_addr;
                        wdata_q    <= bus.lsb_data;
                        mem_dout_q <= bus.lsb_data[7:0];
                    end else if (state_d == READ) begin
                        is_if_q <= if_take;
                        io_q    <= 1'b0;
                        if (if_take) begin
                            n_q     <= 3'd4;
                            mem_a_q <= bus.if_addr;
                        end else begin
                            n_q     <= byte_cnt(bus.lsb_len);
                            mem_a_q <= bus.lsb_addr;
                        end
                    end
                end
                READ: begin
                    if (state_d != IDLE) begin
                        k_q     <= k_q + 3'd1;
                        mem_a_q <= mem_a_q + 32'd1;
                        if (k_q != 3'd0)
                            sh_q <= sh_nxt;
                        if (state_d == COOL) begin
                            if (is_if_q) begin
                                if_flg_q  <= 1'b1;
                                if_inst_q <= rd_word;
                            end else begin
                                lsb_flg_q <= 1'b1;
                                lsb_res_q <= rd_word;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (!wr_stall) begin
                        k_q <= k_q + 3'd1;
                        if (state_d == COOL) begin
                            lsb_commit_q <= 1'b1;
                            mem_dout_q   <= 8'd0;
                        end else begin
                            mem_a_q    <= mem_a_q + 32'd1;
                            mem_dout_q <= wdata_q[15:8];
                            wdata_q    <= {8'd0, wdata_q[31:8]};
                        end
                    end
                end
                COOL:    k_q <= 3'd0;
                default: k_q <= 3'd0;
            endcase
        end
    end

    // A frozen cycle must never repeat a write, so gate with rdy here.
    assign bus.mem_wr     = (state_q == WRITE) && !wr_stall && rdy;
    assign bus.mem_a      = mem_a_q;
    assign bus.mem_dout   = mem_dout_q;
    assign bus.lsb_flg    = lsb_flg_q;
    assign bus.lsb_res    = lsb_res_q;
    assign bus.lsb_commit = lsb_commit_q;
    assign bus.if_flg     = if_flg_q;
    assign bus.if_inst    = if_inst_q;

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 Port: rst  input  1  synchronous, active-high reset.
REQ-003 Port: rdy  input  1  ready; when low, all state and registered outputs hold.
REQ-004 Port: reset  input  1  branch-mispredict flush.
REQ-005 Port: lsb_nd  input  1  load request, held until lsb_flg; lsb_out input 1 store request, held until lsb_commit.
REQ-006 Port: lsb_len  input  6  access width in bits: 8, 16, 32; lsb_addr input 32 byte address; lsb_data input 32 store data.
REQ-007 Port: lsb_flg  output  1  one-cycle load-done pulse; lsb_res output 32 zero-extended load data; lsb_commit output 1 one-cycle store-done pulse.
REQ-008 Port: if_nd  input  1  fetch request, held until if_flg; if_addr input 32; if_flg output 1 one-cycle pulse; if_inst output 32.
REQ-009 Port: mem_din  input  8  RAM read byte; mem_dout output 8; mem_a output 32; mem_wr output 1 (1 = write).
REQ-010 Port: io_buffer_full  input  1  UART buffer full.

Function
REQ-011 States SHALL be IDLE, READ, WRITE, COOL.
REQ-012 In IDLE, priority SHALL be store (lsb_out) > load (lsb_nd) > fetch (if_nd); requests are sampled only in IDLE.
REQ-013 Byte count n SHALL be 1 for lsb_len=8, 2 for 16, and 4 otherwise; fetch always uses n=4.
REQ-014 Byte order SHALL be little-endian: byte k sits at addr+k and occupies bits [8k+7:8k].
REQ-015 RAM read latency SHALL be 1 cycle: mem_din in cycle t+1 carries the byte addressed by mem_a in cycle t.
REQ-016 READ SHALL present addr+0 through addr+n-1 on consecutive cycles and capture n bytes; lsb_flg or if_flg SHALL pulse n+1 cycles after leaving IDLE, then go to COOL.
REQ-017 Load result SHALL be zero-extended to 32 bits; sign extension is the LSB's job.
REQ-018 WRITE SHALL drive mem_wr=1, mem_a=addr+k, and mem_dout=byte k for k=0..n-1, one byte per cycle; lsb_commit SHALL pulse the cycle after the last byte, then go to COOL.
REQ-019 If lsb_addr[17:16]==2'b11 and io_buffer_full=1, WRITE SHALL stall with mem_wr=0 and k unchanged until io_buffer_full drops.
REQ-020 COOL SHALL last exactly 1 cycle with mem_wr=0 and no request accepted, so the requester can drop its held request; then go to IDLE.
REQ-021 reset=1 during IDLE or READ SHALL abort to IDLE with no lsb_flg/if_flg pulse.
REQ-022 reset=1 during WRITE or COOL SHALL NOT abort: a committed store always completes and lsb_commit still pulses.
REQ-023 mem_wr SHALL be gated by rdy (mem_wr=0 whenever rdy=0) so a frozen cycle never repeats a write.
REQ-024 Outside WRITE, mem_wr SHALL be 0 and mem_dout SHALL be 0.
REQ-025 lsb_flg, lsb_commit, and if_flg SHALL be mutually exclusive in any cycle.

Reset
REQ-026 On rst: state=IDLE, mem_wr=0, mem_a=0, mem_dout=0, lsb_flg=0, lsb_commit=0, if_flg=0, lsb_res=0, if_inst=0, byte counter=0.
REQ-027 rst SHALL take priority over rdy and reset; rst mid-WRITE abandons the store.

Structure
REQ-028 The shared def package SHALL hold the state encodings, the IO region tag (2'b11 on [17:16]), and the width codes 8/16/32.
REQ-029 A single flat module with no sub-modules; byte assembly is an inline shift register.

Verification
REQ-030 Fetch: if_nd=1, if_addr=0x100, RAM[0x100..0x103]=13,05,00,00 -> if_flg pulses 5 cycles after acceptance with if_inst=0x00000513; one COOL cycle follows.
REQ-031 Store + fetch same cycle: lsb_out=1 (len=32, addr=0x200, data=0xDEADBEEF) and if_nd=1 -> mem_wr=1 with bytes EF,BE,AD,DE at 0x200..0x203, lsb_commit pulses, then the fetch starts after COOL.
REQ-032 Load byte: lsb_nd=1, len=8, addr=0x301, RAM[0x301]=0x80 -> lsb_flg pulses 2 cycles after acceptance with lsb_res=0x00000080.
REQ-033 IO stall: store len=8 to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr=0 for those 3 cycles, then one write of the byte, then lsb_commit.
REQ-034 Flush: reset=1 at cycle 2 of a fetch -> no if_flg, IDLE next cycle; reset=1 at byte 1 of a 32-bit store -> all 4 bytes written and lsb_commit pulses.
REQ-035 rdy=0 held 2 cycles mid-WRITE -> mem_wr=0 and mem_a unchanged for those cycles, no byte duplicated or lost.
